// File: rtl/pad_attr_ctrl_pkg.sv
// Shared constants for the pad attribute controller: register map, permit masks
// and field layout of the 32-bit attribute registers.
package pad_attr_ctrl_pkg;

   localparam int NMioPads     = 32;
   localparam int NDioPads     = 15;
   localparam int AttrDw       = 10;
   localparam int FieldsPerReg = 3;
   localparam int NRegs        = 17;

   localparam logic [6:0] RegenOffset    = 7'h00;
   localparam logic [6:0] DioPads0Offset = 7'h04;
   localparam logic [6:0] MioPads0Offset = 7'h18;
   localparam logic [6:0] LastOffset     = 7'h40;

   localparam int RegenIdx      = int'(RegenOffset >> 2);
   localparam int DioRegIdx0    = int'(DioPads0Offset >> 2);
   localparam int MioRegIdx0    = int'(MioPads0Offset >> 2);
   localparam int MioRegIdxLast = int'(LastOffset >> 2);

   // Entry i is the byte-permit mask of register i; MIO_PADS10 only spans three bytes.
   localparam logic [NRegs-1:0][3:0] RegPermit = {4'h7, {15{4'hF}}, 4'h1};

   localparam logic [31:0] RsvdMask        = 32'hC000_0000;
   localparam logic [31:0] MioLastRsvdMask = 32'hFFF0_0000;

   function automatic logic [4:0] reg_idx(input logic [6:0] addr);
      return addr[6:2];
   endfunction

endpackage

// File: rtl/pad_attr_field.sv
// One pad attribute register: stores only the bits the pad wrapper can implement.
module pad_attr_field
   import pad_attr_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AttrDw-1:0] wdata,
   input  logic [AttrDw-1:0] warl,
   output logic [AttrDw-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we) begin
         q <= wdata & warl;
      end
   end

endmodule

// File: rtl/pad_attr_ctrl.sv
// Register-mapped pad attribute controller: address decode, permit check, REGEN
// lock and response register around one pad_attr_field per MIO/DIO pad.
module pad_attr_ctrl
   import pad_attr_ctrl_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_i,
   input  logic                       we_i,
   input  logic [6:0]                 addr_i,
   input  logic [31:0]                wdata_i,
   input  logic [3:0]                 be_i,
   output logic                       rvalid_o,
   output logic [31:0]                rdata_o,
   output logic                       err_o,
   input  logic [NMioPads*AttrDw-1:0] mio_warl_i,
   input  logic [NDioPads*AttrDw-1:0] dio_warl_i,
   output logic [NMioPads*AttrDw-1:0] mio_attr_o,
   output logic [NDioPads*AttrDw-1:0] dio_attr_o,
   output logic                       regen_o
);

   // Handshake: req_i is accepted every cycle (no ready); rvalid_o pulses exactly
   // one cycle after each req_i and qualifies rdata_o and err_o.

   logic [4:0]        idx;
   logic [3:0]        permit;
   logic              addr_ok, be_ok, acc_err;
   logic              wr_ok, attr_wr, regen_clr;
   logic              regen_q, rvalid_q, err_q;
   logic [31:0]       rdata_q, rd_word;
   logic [AttrDw-1:0] mio_q [NMioPads];
   logic [AttrDw-1:0] dio_q [NDioPads];
   logic              unused_wdata_rsvd;

   assign unused_wdata_rsvd = ^wdata_i[31:30];

   assign idx     = reg_idx(addr_i);
   assign addr_ok = (addr_i[1:0] == 2'b00) && (addr_i <= LastOffset);

   always_comb begin
      permit = 4'h0;
      if (int'(idx) < NRegs) begin
         permit = RegPermit[idx];
      end
   end

   // A write must enable every byte the register owns; reads ignore be_i.
   assign be_ok     = !we_i || ((permit & ~be_i) == 4'h0);
   assign acc_err   = !addr_ok || !be_ok;
   assign wr_ok     = req_i && we_i && !acc_err;
   assign attr_wr   = wr_ok && regen_q && (int'(idx) != RegenIdx);
   assign regen_clr = wr_ok && (int'(idx) == RegenIdx) && be_i[0] && !wdata_i[0];

   for (genvar p = 0; p < NDioPads; p++) begin : g_dio
      localparam int RegIdx = DioRegIdx0 + p / FieldsPerReg;
      localparam int Lsb    = (p % FieldsPerReg) * AttrDw;
      pad_attr_field u_field (
         .clk   (clk_i),
         .rst_n (rst_ni),
         .we    (attr_wr && (idx == 5'(RegIdx))),
         .wdata (wdata_i[Lsb +: AttrDw]),
         .warl  (dio_warl_i[p*AttrDw +: AttrDw]),
         .q     (dio_q[p])
      );
      assign dio_attr_o[p*AttrDw +: AttrDw] = dio_q[p];
   end

   for (genvar p = 0; p < NMioPads; p++) begin : g_mio
      localparam int RegIdx = MioRegIdx0 + p / FieldsPerReg;
      localparam int Lsb    = (p % FieldsPerReg) * AttrDw;
      pad_attr_field u_field (
         .clk   (clk_i),
         .rst_n (rst_ni),
         .we    (attr_wr && (idx == 5'(RegIdx))),
         .wdata (wdata_i[Lsb +: AttrDw]),
         .warl  (mio_warl_i[p*AttrDw +: AttrDw]),
         .q     (mio_q[p])
      );
      assign mio_attr_o[p*AttrDw +: AttrDw] = mio_q[p];
   end

   always_comb begin
      rd_word = '0;
      if (int'(idx) == RegenIdx) begin
         rd_word[0] = regen_q;
      end else if (int'(idx) < MioRegIdx0) begin
         for (int f = 0; f < FieldsPerReg; f++) begin
            rd_word[f*AttrDw +: AttrDw] = dio_q[(int'(idx) - DioRegIdx0) * FieldsPerReg + f];
         end
      end else if (int'(idx) <= MioRegIdxLast) begin
         for (int f = 0; f < FieldsPerReg; f++) begin
            if ((int'(idx) - MioRegIdx0) * FieldsPerReg + f < NMioPads) begin
               rd_word[f*AttrDw +: AttrDw] = mio_q[(int'(idx) - MioRegIdx0) * FieldsPerReg + f];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         regen_q  <= 1'b1;
      end else begin
         rvalid_q <= req_i;
         err_q    <= req_i && acc_err;
         if (req_i && !we_i && !acc_err) begin
            rdata_q <= rd_word & ~((int'(idx) == MioRegIdxLast) ? MioLastRsvdMask : RsvdMask);
         end else begin
            rdata_q <= '0;
         end
         if (regen_clr) begin
            regen_q <= 1'b0;
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
   assign regen_o  = regen_q;

endmodule

// File: tb/tb_pad_attr_ctrl.sv
// Bench for pad_attr_ctrl: reset readout, vector table, WARL/random writes,
// lock behaviour and asynchronous reset during an in-flight response.
module tb_pad_attr_ctrl;
   import pad_attr_ctrl_pkg::*;

   localparam int MW = NMioPads * AttrDw;
   localparam int DW = NDioPads * AttrDw;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [6:0]    addr_i = '0;
   logic [31:0]   wdata_i = '0;
   logic [3:0]    be_i = '0;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic [MW-1:0] mio_warl_i = '1;
   logic [DW-1:0] dio_warl_i = '1;
   logic [MW-1:0] mio_attr_o;
   logic [DW-1:0] dio_attr_o;
   logic          regen_o;

   // clock/reset block
   always #5 clk_i = ~clk_i;

   pad_attr_ctrl dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .be_i       (be_i),
      .rvalid_o   (rvalid_o),
      .rdata_o    (rdata_o),
      .err_o      (err_o),
      .mio_warl_i (mio_warl_i),
      .dio_warl_i (dio_warl_i),
      .mio_attr_o (mio_attr_o),
      .dio_attr_o (dio_attr_o),
      .regen_o    (regen_o)
   );

   typedef struct {
      logic        we;
      logic [6:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NVec = 16;
   vec_t vecs [NVec];

   // scoreboard: {rvalid, err, rdata} expected one cycle after each driven cycle
   logic [33:0] exp_q [$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AttrDw-1:0] mio_pad(input int k);
      return mio_attr_o[k*AttrDw +: AttrDw];
   endfunction

   function automatic logic [AttrDw-1:0] dio_pad(input int k);
      return dio_attr_o[k*AttrDw +: AttrDw];
   endfunction

   task automatic check_resp(input string name);
      logic [33:0] e;
      if (exp_q.size() == 0) begin
         chk({name, "_noexp"}, 34'h1, 34'h0);
      end else begin
         e = exp_q.pop_front();
         chk(name, {rvalid_o, err_o, rdata_o}, e);
      end
   endtask

   // driver: called at a falling edge, returns at the next falling edge with the
   // response of this access checked
   task automatic acc(input string name, input logic we, input logic [6:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic exp_err, input logic [31:0] exp_rdata);
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
      exp_q.push_back({1'b1, exp_err, exp_rdata});
      @(negedge clk_i);
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
      check_resp(name);
   endtask

   task automatic idle();
      exp_q.push_back(34'h0);
      @(negedge clk_i);
      check_resp("idle");
   endtask

   initial begin
      int          r;
      int          pad;
      logic [31:0] d, e;
      logic [AttrDw-1:0] w;

      vecs[0]  = '{1'b1, 7'h1C, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 7'h1C, 32'h0,         4'hF, 1'b0, 32'h3FFF_FFFF};
      vecs[2]  = '{1'b1, 7'h04, 32'h0000_03FF, 4'hF, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 7'h04, 32'h0,         4'hF, 1'b0, 32'h0000_000F};
      vecs[4]  = '{1'b1, 7'h40, 32'hFFFF_FFFF, 4'h3, 1'b1, 32'h0};
      vecs[5]  = '{1'b0, 7'h40, 32'h0,         4'hF, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 7'h40, 32'hFFFF_FFFF, 4'h7, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 7'h40, 32'h0,         4'hF, 1'b0, 32'h000F_FFFF};
      vecs[8]  = '{1'b0, 7'h44, 32'h0,         4'hF, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 7'h05, 32'h0,         4'hF, 1'b1, 32'h0};
      vecs[10] = '{1'b1, 7'h14, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
      vecs[11] = '{1'b0, 7'h14, 32'h0,         4'hF, 1'b0, 32'h1EAD_BEEF};
      vecs[12] = '{1'b1, 7'h00, 32'h0,         4'hE, 1'b1, 32'h0};
      vecs[13] = '{1'b0, 7'h00, 32'h0,         4'h0, 1'b0, 32'h0000_0001};
      vecs[14] = '{1'b1, 7'h18, 32'h0000_0155, 4'hF, 1'b0, 32'h0};
      vecs[15] = '{1'b0, 7'h18, 32'h0,         4'h0, 1'b0, 32'h0000_0155};

      // reset values
      repeat (2) @(negedge clk_i);
      chk("rst_rvalid", 34'(rvalid_o), 34'h0);
      chk("rst_rdata", 34'(rdata_o), 34'h0);
      chk("rst_err", 34'(err_o), 34'h0);
      chk("rst_regen", 34'(regen_o), 34'h1);
      chk("rst_mio", 34'(mio_attr_o != '0), 34'h0);
      chk("rst_dio", 34'(dio_attr_o != '0), 34'h0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < NRegs; i++) begin
         acc("rst_read", 1'b0, 7'(i * 4), 32'h0, 4'hF, 1'b0, (i == 0) ? 32'h1 : 32'h0);
      end
      idle();

      // vector table, warl all ones except DIO pad 0
      dio_warl_i[9:0] = 10'h00F;
      for (int i = 0; i < NVec; i++) begin
         acc($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_err, vecs[i].exp_rdata);
      end
      chk("mio_pad3", 34'(mio_pad(3)), 34'h3FF);
      chk("mio_pad5", 34'(mio_pad(5)), 34'h3FF);
      chk("mio_pad30", 34'(mio_pad(30)), 34'h3FF);
      chk("mio_pad31", 34'(mio_pad(31)), 34'h3FF);
      chk("mio_pad0", 34'(mio_pad(0)), 34'h155);
      chk("dio_pad0", 34'(dio_pad(0)), 34'h00F);
      d = 32'hDEAD_BEEF;
      for (int f = 0; f < 3; f++) begin
         chk("dio_pad12_14", 34'(dio_pad(12 + f)), 34'(d[f*AttrDw +: AttrDw]));
      end

      // attribute output changes exactly one cycle after the write
      chk("pad9_before", 34'(mio_pad(9)), 34'h0);
      acc("wr_mio3", 1'b1, 7'h24, 32'h3FFF_FFFF, 4'hF, 1'b0, 32'h0);
      chk("pad9_after", 34'(mio_pad(9)), 34'h3FF);

      // WARL change leaves stored values alone, applies to the next write
      for (int p = 0; p < NMioPads; p++) mio_warl_i[p*AttrDw +: AttrDw] = 10'($urandom_range(0, 1023));
      for (int p = 0; p < NDioPads; p++) dio_warl_i[p*AttrDw +: AttrDw] = 10'($urandom_range(0, 1023));
      @(negedge clk_i);
      chk("warl_keep", 34'(mio_pad(4)), 34'h3FF);
      acc("warl_keep_rd", 1'b0, 7'h1C, 32'h0, 4'hF, 1'b0, 32'h3FFF_FFFF);

      for (int n = 0; n < 8; n++) begin
         r = $urandom_range(1, 15);
         d = $urandom();
         e = '0;
         for (int f = 0; f < 3; f++) begin
            pad = (r < 6) ? (r - 1) * 3 + f : (r - 6) * 3 + f;
            w = (r < 6) ? dio_warl_i[pad*AttrDw +: AttrDw] : mio_warl_i[pad*AttrDw +: AttrDw];
            e[f*AttrDw +: AttrDw] = d[f*AttrDw +: AttrDw] & w;
         end
         acc("rnd_wr", 1'b1, 7'(r * 4), d, 4'hF, 1'b0, 32'h0);
         pad = (r < 6) ? (r - 1) * 3 : (r - 6) * 3;
         chk("rnd_out", 34'((r < 6) ? dio_pad(pad) : mio_pad(pad)), 34'(e[9:0]));
         acc("rnd_rd", 1'b0, 7'(r * 4), 32'h0, 4'hF, 1'b0, e);
      end

      // lock
      mio_warl_i = '1;
      dio_warl_i = '1;
      acc("pre_lock_wr", 1'b1, 7'h18, 32'h0000_0155, 4'hF, 1'b0, 32'h0);
      acc("regen_clr", 1'b1, 7'h00, 32'h0, 4'h1, 1'b0, 32'h0);
      chk("regen_low", 34'(regen_o), 34'h0);
      acc("locked_wr", 1'b1, 7'h18, 32'h0000_02AA, 4'hF, 1'b0, 32'h0);
      chk("locked_pad0", 34'(mio_pad(0)), 34'h155);
      acc("locked_rd", 1'b0, 7'h18, 32'h0, 4'hF, 1'b0, 32'h0000_0155);
      acc("regen_set", 1'b1, 7'h00, 32'h1, 4'h1, 1'b0, 32'h0);
      chk("regen_stuck", 34'(regen_o), 34'h0);
      acc("regen_rd", 1'b0, 7'h00, 32'h0, 4'hF, 1'b0, 32'h0);
      acc("locked_err", 1'b1, 7'h42, 32'h0, 4'hF, 1'b1, 32'h0);

      // asynchronous reset with a response in flight
      req_i = 1'b1; we_i = 1'b0; addr_i = 7'h18; be_i = 4'hF;
      @(posedge clk_i);
      #2;
      chk("inflight", {rvalid_o, err_o, rdata_o}, {1'b1, 1'b0, 32'h0000_0155});
      rst_ni = 1'b0;
      req_i = 1'b0; addr_i = '0; be_i = '0;
      #1;
      chk("midrst_rvalid", 34'(rvalid_o), 34'h0);
      chk("midrst_rdata", 34'(rdata_o), 34'h0);
      chk("midrst_regen", 34'(regen_o), 34'h1);
      chk("midrst_mio", 34'(mio_attr_o != '0), 34'h0);
      chk("midrst_dio", 34'(dio_attr_o != '0), 34'h0);
      exp_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      acc("release_wr", 1'b1, 7'h20, 32'h0000_03FF, 4'hF, 1'b0, 32'h0);
      chk("release_pad6", 34'(mio_pad(6)), 34'h3FF);
      acc("release_rd", 1'b0, 7'h20, 32'h0, 4'hF, 1'b0, 32'h0000_03FF);
      acc("release_regen", 1'b0, 7'h00, 32'h0, 4'hF, 1'b0, 32'h1);
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pad_attr_ctrl.md
Name: pad_attr_ctrl

Overview:
Register-mapped pad attribute controller: the software-facing writer for pad attributes consumed by the pad ring.
- Takes single-cycle register-bus accesses and stores one AttrDw-bit attribute per MIO and DIO pad.
- Masks each stored attribute with the write-any-read-legal (WARL) capability mask reported by the pad wrappers.
- Drives the packed mio_attr_o / dio_attr_o buses into the pad ring.
- A clear-only lock register (REGEN) freezes all attribute registers until reset.

Parameters:
NMioPads, 32, number of multiplexed IO pads (register map is fixed for 32).
NDioPads, 15, number of dedicated IO pads (register map is fixed for 15).
AttrDw, 10, attribute width per pad (fixed 10; three fields per 32-bit register).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  access request, always accepted (no backpressure)
we_i  in  1  1=write, 0=read
addr_i  in  7  byte address
wdata_i  in  32  write data
be_i  in  4  byte enables
rvalid_o  out  1  response valid, one cycle after req_i
rdata_o  out  32  read data (0 for writes and errors)
err_o  out  1  access error, qualified by rvalid_o
mio_warl_i  in  NMioPads*AttrDw  per-pad implementable-bit mask
dio_warl_i  in  NDioPads*AttrDw  per-pad implementable-bit mask
mio_attr_o  out  NMioPads*AttrDw  packed MIO attributes; pad k at [k*AttrDw +: AttrDw]
dio_attr_o  out  NDioPads*AttrDw  packed DIO attributes
regen_o  out  1  current lock-enable state (1 = writable)

Behaviour:
- Clock/reset: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: all attribute registers 0; REGEN=1; rvalid_o=0, rdata_o=0, err_o=0; mio_attr_o=0, dio_attr_o=0, regen_o=1.
- Register map (word-aligned):
  - REGEN 0x00, bit0, rw0c.
  - DIO_PADS0..4 at 0x04..0x14.
  - MIO_PADS0..10 at 0x18..0x40.
- Field layout: register n holds pads 3n, 3n+1, 3n+2 at [9:0], [19:10], [29:20]. Bits [31:30] are reserved, read 0, writes ignored. MIO_PADS10 holds pads 30 and 31 only; bits [31:20] read 0.
- Permit masks: REGEN 4'b0001; DIO_PADS0..4 and MIO_PADS0..9 4'b1111; MIO_PADS10 4'b0111.
- Access timing: a request in cycle N commits writes at the edge ending cycle N. Response (rvalid_o, rdata_o, err_o) is registered and valid in cycle N+1. Back-to-back requests are accepted every cycle; a read in N+1 sees a write from N.
- Attribute outputs: registered and update in cycle N+1 after a committed write. Stored field = wdata field AND the corresponding warl_i slice sampled in cycle N. Reads return the stored (masked) value.
- REGEN: a write with be_i[0]=1 and wdata_i[0]=0 clears it to 0. Writing 1 has no effect. Only reset sets it back to 1.
- Lock: when REGEN=0, writes to attribute registers are dropped silently (err_o=0, no change). Reads still work.
- Errors (err_o=1, no state change, rdata_o=0):
  - addr_i[1:0]!=0, or addr_i > 0x40;
  - a write with (permit & ~be_i)!=0, i.e. partial write of a permitted byte. Reads ignore be_i.
- Idle cycles: when req_i=0, rvalid_o=0 next cycle, and rdata_o/err_o are 0.
- Reset mid-operation: asserting rst_ni low clears everything immediately, including an in-flight response. A write in the reset-release cycle is honoured normally.
- WARL changes: changes to warl_i do not alter stored values; they apply only at the next write.

Decomposition:
- pad_attr_ctrl_pkg holds: register offsets, register index constants, the 17-entry permit array, field count per register (3), reserved-bit masks.
- One sub-module, pad_attr_field: a single AttrDw-bit register with write enable, WARL masking, reset to 0. It is instantiated NMioPads+NDioPads times in generate loops. Top level does address decode, permit check, lock and the response register.

Test Plan:
1. Reset, then read all 17 offsets -> each read: rvalid_o one cycle later, err_o=0. REGEN reads 0x00000001; every other register reads 0x00000000.
2. warl all-ones; write MIO_PADS1=0xFFFFFFFF with be=4'hF -> mio_attr_o pads 3,4,5 = 0x3FF the next cycle; readback = 0x3FFFFFFF.
3. dio_warl_i pad 0 = 0x00F; write DIO_PADS0=0x000003FF -> dio_attr_o[9:0]=0x00F; readback 0x0000000F.
4. Write REGEN=0, then write MIO_PADS0=0x155 -> err_o=0, mio_attr_o unchanged. Write REGEN=1 -> regen_o stays 0.
5. Write MIO_PADS10 with be=4'h3 -> err_o=1, no change; with be=4'h7 -> accepted. Access 0x44 or 0x05 -> err_o=1, rdata_o=0.
6. Write DIO_PADS4 in cycle N, read it in cycle N+1 -> new value returned. Assert rst_ni mid-sequence -> all outputs at reset values immediately.
